// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // mul_signed encodings: bit1 = multiplicand signed, bit0 = multiplier signed
  localparam logic [1:0] SS = 2'b11;
  localparam logic [1:0] SU = 2'b10;
  localparam logic [1:0] US = 2'b01;
  localparam logic [1:0] UU = 2'b00;

  // Iterations needed to retire all Booth digits at 'steps' digits per cycle.
  function automatic int unsigned calc_iters(int unsigned xlen, int unsigned steps, logic w);
    int unsigned d;
    d = w ? 32'd17 : (xlen / 2 + 1);
    return (d + steps - 1) / steps;
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// One radix-4 Booth digit: selects 0/M/2M and reports whether it must be negated.
module booth_r4_digit #(
  parameter int unsigned W = 130
) (
  input  logic [2:0]   win,
  input  logic [W-1:0] mcand,
  output logic [W-1:0] pp,
  output logic         neg
);

  logic [W-1:0] mag;

  always_comb begin
    mag = '0;
    unique case (win)
      3'b001, 3'b010, 3'b101, 3'b110: mag = mcand;
      3'b011, 3'b100:                 mag = mcand << 1;
      default:                        mag = '0;
    endcase
  end

  // Negation is one's complement here; the +1 is folded into the accumulator add.
  assign neg = win[2] & ~(win[1] & win[0]);
  assign pp  = neg ? ~mag : mag;

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier with ready/valid handshakes, flush and optional W mode.
module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned STEPS = 1,
  parameter bit          HAS_W = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  localparam int unsigned EW   = XLEN + 2;
  localparam int unsigned AW   = 2 * XLEN + 2;
  localparam int unsigned MW   = XLEN + 3;
  localparam int unsigned CW   = $clog2(XLEN) + 1;
  localparam bit          W_OK = HAS_W && (XLEN == 64);

  state_t          state;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_next;
  logic [AW-1:0]   mcand_sh;
  logic [MW-1:0]   mplr;
  logic [CW-1:0]   cnt;
  logic            w_mode;
  logic            w_in;
  logic [EW-1:0]   a_ext, b_ext, a_w, b_w, op_a, op_b;
  logic [XLEN-1:0] w_hi, w_lo, fmt_hi, fmt_lo;
  logic [AW-1:0]   pp [STEPS];
  logic [STEPS-1:0] neg;

  assign in_ready = (state == IDLE) && !rst;
  assign w_in     = W_OK && mulw;

  assign a_ext = {{2{mul_signed[1] & multiplicand[XLEN-1]}}, multiplicand};
  assign b_ext = {{2{mul_signed[0] & multiplier[XLEN-1]}}, multiplier};

  generate
    if (W_OK) begin : g_w
      assign a_w  = {{(EW-32){multiplicand[31]}}, multiplicand[31:0]};
      assign b_w  = {{(EW-32){multiplier[31]}}, multiplier[31:0]};
      assign w_hi = acc_next[XLEN-1:0];
      assign w_lo = {{(XLEN-32){acc_next[31]}}, acc_next[31:0]};
    end else begin : g_no_w
      assign a_w  = '0;
      assign b_w  = '0;
      assign w_hi = '0;
      assign w_lo = '0;
    end
  endgenerate

  assign op_a = w_in ? a_w : a_ext;
  assign op_b = w_in ? b_w : b_ext;

  // Multiplicand is pre-shifted each cycle so digit j only needs a constant 2*j offset.
  for (genvar j = 0; j < STEPS; j++) begin : g_dig
    logic [AW-1:0] mc_j;
    assign mc_j = mcand_sh << (2 * j);
    booth_r4_digit #(.W(AW)) u_dig (
      .win   (mplr[2*j+2:2*j]),
      .mcand (mc_j),
      .pp    (pp[j]),
      .neg   (neg[j])
    );
  end

  always_comb begin
    acc_next = acc;
    for (int unsigned j = 0; j < STEPS; j++) begin
      acc_next = acc_next + pp[j] + AW'(neg[j]);
    end
  end

  assign fmt_hi = w_mode ? w_hi : acc_next[2*XLEN-1:XLEN];
  assign fmt_lo = w_mode ? w_lo : acc_next[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      acc       <= '0;
      mcand_sh  <= '0;
      mplr      <= '0;
      cnt       <= '0;
      w_mode    <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= '0;
            mcand_sh <= {{(AW-EW){op_a[EW-1]}}, op_a};
            mplr     <= {op_b, 1'b0};
            cnt      <= CW'(calc_iters(XLEN, STEPS, w_in) - 1);
            w_mode   <= w_in;
            state    <= CALC;
          end
        end
        CALC: begin
          acc      <= acc_next;
          mcand_sh <= mcand_sh << (2 * STEPS);
          // Arithmetic shift keeps surplus digits (when STEPS does not divide D) at zero.
          mplr     <= MW'($signed(mplr) >>> (2 * STEPS));
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result_hi <= fmt_hi;
            result_lo <= fmt_lo;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
